hazard_scoreboard: RTL

- Consumes the per-instruction register-usage decode from the ID stage: source indices, source-valid flags, write-valid flag and destination index.
- Tracks in-flight register writers through the EX, MEM and WB stages and raises a stall to the fetch/decode pipeline when a source operand depends on a pending write that cannot be forwarded.
- Inserts bubbles into ID/EX while stalling and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard.sv | 99 +++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage register-usage decode in,
// stall / pending-writer view and stall counter out.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [2:0]       id_Rs;
  logic [2:0]       id_Rt;
  logic             id_RsValid;
  logic             id_RtValid;
  logic             id_writeRegValid;
  logic [2:0]       id_writeReg;
  logic             id_isStore;
  logic             id_isLoad;
  logic             flush;
  logic             hold;
  logic             stall;
  logic [7:0]       pend_mask;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_Rs, id_Rt,
    output id_RsValid, id_RtValid,
    output id_writeRegValid, id_writeReg,
    output id_isStore, id_isLoad,
    output flush, hold,
    input  stall, pend_mask, stall_count
  );

  modport slave (
    input  id_valid, id_Rs, id_Rt,
    input  id_RsValid, id_RtValid,
    input  id_writeRegValid, id_writeReg,
    input  id_isStore, id_isLoad,
    input  flush, hold,
    output stall, pend_mask, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks EX/MEM/WB register writers and
// stalls fetch/decode on operands that cannot be forwarded.
module hazard_scoreboard #(
  parameter bit FORWARDING = 1'b1,
  parameter bit RF_BYPASS  = 1'b1,
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave sb
);

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       ld;
  } ent_t;

  ent_t e0, e1, e2;
  ent_t e0_nxt;

  logic             wr;
  logic             m0, m1, m2;
  logic             stall_c;
  logic [7:0]       mask;
  logic [CNT_W-1:0] cnt;

  function automatic logic hit(
    input ent_t       e,
    input logic [2:0] rs,
    input logic       rsv,
    input logic [2:0] rt,
    input logic       rtv
  );
    return e.v & ((rsv & (rs == e.rd)) |
                  (rtv & (rt == e.rd)));
  endfunction

  // Stores carry writeRegValid from decode but never write back.
  assign wr = sb.id_valid & sb.id_writeRegValid
            & ~sb.id_isStore;

  assign m0 = sb.id_valid & hit(e0, sb.id_Rs,
    sb.id_RsValid, sb.id_Rt, sb.id_RtValid);
  assign m1 = sb.id_valid & hit(e1, sb.id_Rs,
    sb.id_RsValid, sb.id_Rt, sb.id_RtValid);
  assign m2 = sb.id_valid & hit(e2, sb.id_Rs,
    sb.id_RsValid, sb.id_Rt, sb.id_RtValid);

  // Stall decision; a redirect always beats a hazard.
  always_comb begin
    stall_c = 1'b0;
    if (sb.flush | ~sb.id_valid)
      stall_c = 1'b0;
    else if (FORWARDING)
      stall_c = m0 & e0.ld;
    else
      stall_c = m0 | m1 | (m2 & ~RF_BYPASS);
  end

  // Next EX entry: the decoded writer, or a bubble.
  always_comb begin
    e0_nxt = '0;
    if (~stall_c & ~sb.flush) begin
      e0_nxt.v  = wr;
      e0_nxt.rd = sb.id_writeReg;
      e0_nxt.ld = sb.id_isLoad;
    end
  end

  // One-hot OR of every register still being written.
  always_comb begin
    mask = '0;
    if (e0.v) mask[e0.rd] = 1'b1;
    if (e1.v) mask[e1.rd] = 1'b1;
    if (e2.v) mask[e2.rd] = 1'b1;
  end

  // Advance the writer pipeline and count stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      e2  <= '0;
      cnt <= '0;
    end else if (~sb.hold) begin
      e2 <= e1;
      e1 <= e0;
      e0 <= e0_nxt;
      if (stall_c & ~&cnt)
        cnt <= cnt + 1'b1;
    end
  end

  assign sb.stall       = stall_c;
  assign sb.pend_mask   = mask;
  assign sb.stall_count = cnt;

endmodule
